// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with owner-steered address/strobe/data mux; grants held until released.
// Optional grant watchdog compiled in with BUS_ARB_WATCHDOG_EN.
module bus_arbiter #(
  parameter int NUM_M     = 4,
  parameter int TO_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [NUM_M-1:0]     MReq_,
  input  logic [NUM_M*30-1:0]  MAddr,
  input  logic [NUM_M-1:0]     MAs_,
  input  logic [NUM_M-1:0]     MRW,
  input  logic [NUM_M*32-1:0]  MWrData,
  output logic [NUM_M-1:0]     MGrnt_,
  output logic [29:0]          SAddr,
  output logic                 SAs_,
  output logic                 SRW,
  output logic [31:0]          SWrData,
  output logic                 ArbTimeout
);

  logic [1:0]       owner, owner_nxt, pick, cand;
  logic             busy, busy_nxt, found, revoke;
  logic [3:0]       req;
  logic [NUM_M-1:0] grnt_nxt;

  // Active-high requests padded to four so absent masters never match.
  always_comb begin
    req = '0;
    req[NUM_M-1:0] = ~MReq_;
  end

  // Search owner+1 .. owner; the current owner is checked last, or skipped on a revoke.
  always_comb begin
    found = 1'b0;
    pick  = owner;
    cand  = owner;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = 2'((int'(owner) + k) % NUM_M);
      if (!found && req[cand] && !(revoke && cand == owner)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    owner_nxt = owner;
    busy_nxt  = busy;
    if (!busy || !req[owner] || revoke) begin
      busy_nxt = found;
      if (found) owner_nxt = pick;
    end
    grnt_nxt = '1;
    if (busy_nxt) grnt_nxt[owner_nxt] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      owner  <= 2'(NUM_M - 1);
      busy   <= 1'b0;
      MGrnt_ <= '1;
    end else begin
      owner  <= owner_nxt;
      busy   <= busy_nxt;
      MGrnt_ <= grnt_nxt;
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  logic [CW-1:0] wd_cnt;

  assign revoke = busy && req[owner] && (wd_cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wd_cnt     <= '0;
      ArbTimeout <= 1'b0;
    end else begin
      ArbTimeout <= revoke;
      if (busy && busy_nxt && owner_nxt == owner) wd_cnt <= wd_cnt + CW'(1);
      else                                        wd_cnt <= '0;
    end
  end
`else
  logic unused_to;
  assign unused_to  = (TO_CYCLES > 0);
  assign revoke     = 1'b0;
  assign ArbTimeout = 1'b0;
`endif

  // Only the owner reaches the bus; an idle bus reads as a parked read cycle.
  always_comb begin
    SAddr   = '0;
    SAs_    = 1'b1;
    SRW     = 1'b1;
    SWrData = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (busy && owner == 2'(i)) begin
        SAddr   = MAddr[i*30 +: 30];
        SAs_    = MAs_[i];
        SRW     = MRW[i];
        SWrData = MWrData[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_bus_arbiter;

  localparam int NM = 4;

  logic              clk = 1'b0;
  logic              reset_;
  logic [NM-1:0]     MReq_;
  logic [NM*30-1:0]  MAddr;
  logic [NM-1:0]     MAs_;
  logic [NM-1:0]     MRW;
  logic [NM*32-1:0]  MWrData;
  logic [NM-1:0]     MGrnt_;
  logic [29:0]       SAddr;
  logic              SAs_;
  logic              SRW;
  logic [31:0]       SWrData;
  logic              ArbTimeout;

  logic [29:0] a  [NM];
  logic [31:0] d  [NM];
  logic        as [NM];
  logic        rw [NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      MAddr[i*30 +: 30]   = a[i];
      MWrData[i*32 +: 32] = d[i];
      MAs_[i]             = as[i];
      MRW[i]              = rw[i];
    end
  end

  bus_arbiter #(.NUM_M(NM), .TO_CYCLES(8)) dut (
    .clk(clk), .reset_(reset_), .MReq_(MReq_), .MAddr(MAddr), .MAs_(MAs_),
    .MRW(MRW), .MWrData(MWrData), .MGrnt_(MGrnt_), .SAddr(SAddr), .SAs_(SAs_),
    .SRW(SRW), .SWrData(SWrData), .ArbTimeout(ArbTimeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          tag;
    logic [3:0]  grnt;
    logic [29:0] saddr;
    logic        sas;
    logic        srw;
    logic [31:0] swd;
    logic        to;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
    end
  endtask

  // Drive this cycle's inputs and record what must be seen after the next edge.
  task automatic apply(input logic rst, input logic [3:0] req, input int own, input logic to, input string nm);
    exp_t e;
    reset_ = rst;
    MReq_  = req;
    e.tag  = cyc + 1;
    e.to   = to;
    if (own < 0) begin
      e.grnt = 4'hF; e.saddr = '0; e.sas = 1'b1; e.srw = 1'b1; e.swd = '0;
    end else begin
      e.grnt = 4'hF & ~(4'h1 << own);
      e.saddr = a[own]; e.sas = as[own]; e.srw = rw[own]; e.swd = d[own];
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic rst, input logic [3:0] req, input int own, input logic to, input string nm);
    @(negedge clk); #1;
    apply(rst, req, own, to, nm);
  endtask

  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk); #2;
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.tag < cyc) begin
          chk(nm, "stale", 32'(cyc), 32'(e.tag));
        end else begin
          chk(nm, "grant",   32'(MGrnt_),     32'(e.grnt));
          chk(nm, "saddr",   32'(SAddr),      32'(e.saddr));
          chk(nm, "sas",     32'(SAs_),       32'(e.sas));
          chk(nm, "srw",     32'(SRW),        32'(e.srw));
          chk(nm, "swdata",  SWrData,         e.swd);
          chk(nm, "timeout", 32'(ArbTimeout), 32'(e.to));
        end
      end
    end
  end

  initial begin
    a[0] = 30'h0000_0111; a[1] = 30'h0000_0222; a[2] = 30'h0000_1234; a[3] = 30'h0000_0333;
    d[0] = 32'hD000_0000; d[1] = 32'hD111_1111; d[2] = 32'hD222_2222; d[3] = 32'hD333_3333;
    rw[0] = 1'b1; rw[1] = 1'b0; rw[2] = 1'b1; rw[3] = 1'b0;
    for (int i = 0; i < NM; i++) as[i] = 1'b0;
    reset_ = 1'b0;
    MReq_  = 4'hF;

    step(1'b0, 4'b1111, -1, 1'b0, "reset0");
    step(1'b0, 4'b1111, -1, 1'b0, "reset1");
    step(1'b1, 4'b1111, -1, 1'b0, "idle");

    step(1'b1, 4'b1011,  2, 1'b0, "single_grant");
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1011, 2, 1'b0, "single_hold");
    step(1'b1, 4'b1111, -1, 1'b0, "single_release");
    step(1'b1, 4'b1111, -1, 1'b0, "single_idle");

    step(1'b0, 4'b1111, -1, 1'b0, "rr_reset");
    step(1'b1, 4'b0000,  0, 1'b0, "rr_g0");
    step(1'b1, 4'b0000,  0, 1'b0, "rr_h0");
    step(1'b1, 4'b0000,  0, 1'b0, "rr_h0");
    step(1'b1, 4'b0001,  1, 1'b0, "rr_g1");
    step(1'b1, 4'b0000,  1, 1'b0, "rr_h1");
    step(1'b1, 4'b0000,  1, 1'b0, "rr_h1");
    step(1'b1, 4'b0010,  2, 1'b0, "rr_g2");
    step(1'b1, 4'b0000,  2, 1'b0, "rr_h2");
    step(1'b1, 4'b0000,  2, 1'b0, "rr_h2");
    step(1'b1, 4'b0100,  3, 1'b0, "rr_g3");
    step(1'b1, 4'b0000,  3, 1'b0, "rr_h3");
    step(1'b1, 4'b0000,  3, 1'b0, "rr_h3");
    step(1'b1, 4'b1000,  0, 1'b0, "rr_wrap0");

    step(1'b1, 4'b1101,  1, 1'b0, "own1");
    @(negedge clk); #1;
    a[0] = 30'h3FFF_FFFF;
    apply(1'b1, 4'b1101, 1, 1'b0, "iso_m0_strobe");
    @(negedge clk); #1;
    as[1] = 1'b1;
    apply(1'b1, 4'b1101, 1, 1'b0, "iso_owner_nostrobe");
    @(negedge clk); #1;
    as[1] = 1'b0;
    apply(1'b1, 4'b0110, 3, 1'b0, "simul_pick3");
    step(1'b1, 4'b1110,  0, 1'b0, "simul_then0");
    step(1'b1, 4'b1111, -1, 1'b0, "simul_idle");

    for (int k = 1; k <= 20; k++) begin
`ifdef BUS_ARB_WATCHDOG_EN
      if (k == 9 || k == 18) step(1'b1, 4'b1110, -1, 1'b1, "wd_revoke");
      else                   step(1'b1, 4'b1110,  0, 1'b0, "wd_hold");
`else
      step(1'b1, 4'b1110, 0, 1'b0, "hold20");
`endif
    end
    step(1'b0, 4'b1110, -1, 1'b0, "mid_reset");
    step(1'b1, 4'b1111, -1, 1'b0, "post_reset");

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) chk("drain", "pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
